sum_of_squares_seq: RTL
=======================

// Module: sum_of_squares_seq
// PURPOSE
//  Computes the squared magnitude |v|^2 = sum(v_i^2) of an N-element signed fixed-point vector.
//  Uses one shared multiplier and a sequential multiply-accumulate (one element per cycle).
//  Sits directly upstream of the fastInvSqrt stage in the Madgwick normalisation path.
//  Its output (same Q format, non-negative, saturated) feeds fastInvSqrt data_in over valid/ready.
// PARAMETERS
//  INT_WIDTH    4  integer bits of Q format, sign bit included (W = INT_WIDTH+FRACT_WIDTH)
//  FRACT_WIDTH  6  fractional bits of Q format
//  N_ELEM       4  vector elements, legal range 2..8 (3 = accel/mag vector, 4 = quaternion)
// PORTS
//  clk        in   1         system clock, all state changes on rising edge
//  rst        in   1         asynchronous, active-low reset (0 = reset)
//  data_in    in   N_ELEM*W  packed vector; element i at [i*W +: W], two's complement Q(INT).(FRACT)
//  valid_in   in   1         upstream vector valid
//  ready_in   out  1         block can accept a vector
//  data_out   out  W         |v|^2 in Q(INT).(FRACT), always >= 0
//  valid_out  out  1         data_out valid
//  ready_out  in   1         downstream (fastInvSqrt) accepts result
//  overflow   out  1         result was saturated; qualified by valid_out
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ready_in=0, valid_out=0, data_out=0, overflow=0, acc=0, idx=0.
//  ready_in is registered: it rises on the first clk edge after rst release, then equals (state==IDLE).
//  FSM states: IDLE, MAC, DONE.
//  IDLE: ready_in=1. On an edge with valid_in&&ready_in, capture data_in into vec_reg, acc=0, idx=0,
//   ready_in->0, go to MAC. data_in may change freely after that edge.
//  MAC: each edge adds sq(vec_reg[idx]) to acc and increments idx. At the edge processing idx==N_ELEM-1,
//   register the result into data_out/overflow, set valid_out=1, and go to DONE.
//  Latency: valid_out rises exactly N_ELEM cycles after the input handshake edge.
//  DONE: valid_out=1. data_out and overflow are held stable while ready_out=0 (unbounded backpressure).
//   On an edge with valid_out&&ready_out: valid_out->0, ready_in->1, go to IDLE.
//   There is no same-cycle pass-through; throughput is at most 1 vector per N_ELEM+2 cycles.
//  Arithmetic:
//   - sq = elem*elem as signed W x signed W, giving a 2W-bit product in Q(2INT).(2FRACT), non-negative.
//   - acc width = 2W + clog2(N_ELEM), unsigned, so it never wraps.
//   - result = acc >> FRACT_WIDTH (truncation/floor, no rounding).
//   - If result > 2^(W-1)-1: data_out = 2^(W-1)-1 (0111..1) and overflow=1; otherwise overflow=0.
//  Boundaries:
//   - -2^(INT_WIDTH-1) (most negative code) squares correctly and does not wrap.
//   - An all-zero vector gives data_out=0 with valid_out still asserted.
//   - valid_in during MAC/DONE is ignored, not queued.
//   - valid_out never drops without a handshake.
//  Reset mid-MAC or mid-DONE: the in-flight vector is discarded and outputs return to reset values immediately.
// TESTING (defaults W=10, N_ELEM=4; values shown as bit patterns)
//  1 vec (0.5,0.5,0.5,0.5) = 4x 0000_1000_00, ready_out=1 -> data_out=0001_0000_00 (1.0),
//    overflow=0, valid_out 4 cycles after accept.
//  2 vec (1.5,-1.0,0,0.5) -> 3.5 = 0011_1000_00, overflow=0 (checks negative operand and zero element).
//  3 vec (3.0,3.0,0,0) -> 18 saturates: data_out=0111_1111_11, overflow=1;
//    vec (-8,0,0,0) = 1000_0000_00 -> same saturated result.
//  4 vec (0.125,0,0,0) -> 0000_0000_01; vec (1 LSB,1 LSB,1 LSB,1 LSB) -> 0000_0000_00 (truncation).
//  5 backpressure: hold ready_out=0 for 6 cycles after valid_out -> data_out stable, ready_in=0,
//    new valid_in ignored; ready_out=1 -> ready_in=1 the next cycle.
//  6 assert rst=0 two cycles into MAC -> valid_out=0, ready_in=0 asynchronously; after release,
//    vector from test 1 gives 0001_0000_00 again.

Source files
------------

// File: rtl/sum_of_squares_seq.sv
// Squared magnitude |v|^2 of an N_ELEM-element signed Q(INT).(FRACT) vector.
// A single shared multiplier squares one element per cycle into a wide
// accumulator. The floored result is saturated to the positive Q range and
// handed downstream (to fastInvSqrt) over valid/ready.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready_in high, waiting for a vector handshake
// MAC   | squaring vec_reg[idx] into acc, one element per cycle
// DONE  | result on data_out with valid_out high, held until ready_out
module sum_of_squares_seq #(
  parameter int INT_WIDTH   = 4,
  parameter int FRACT_WIDTH = 6,
  parameter int N_ELEM      = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [N_ELEM*(INT_WIDTH+FRACT_WIDTH)-1:0]  data_in,
  input  logic                                       valid_in,
  output logic                                       ready_in,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0]           data_out,
  output logic                                       valid_out,
  input  logic                                       ready_out,
  output logic                                       overflow
);

  localparam int W     = INT_WIDTH + FRACT_WIDTH;
  localparam int IDX_W = $clog2(N_ELEM);
  // Extra clog2(N_ELEM) bits so N_ELEM worst-case squares can never wrap.
  localparam int ACC_W = 2 * W + $clog2(N_ELEM);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [W-1:0]     MAX_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MAX_ACC  = {{(ACC_W-W){1'b0}}, MAX_POS};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic signed [W-1:0] vec_reg [N_ELEM];
  logic [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]   idx;

  logic signed [W-1:0]   elem;
  logic signed [2*W-1:0] sq;
  logic [ACC_W-1:0]      acc_next;
  logic [ACC_W-1:0]      result;
  logic                  sat;
  logic [W-1:0]          sat_val;

  // Square of the current element; a signed square is never negative, so it
  // is zero-extended into the unsigned accumulator.
  always_comb begin
    elem     = vec_reg[idx];
    sq       = elem * elem;
    acc_next = acc + {{(ACC_W-2*W){1'b0}}, sq};
    result   = acc_next >> FRACT_WIDTH;
    sat      = (result > MAX_ACC);
    sat_val  = sat ? MAX_POS : result[W-1:0];
  end

  // Sequencer: capture vector, accumulate one square per cycle, hold result until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ready_in  <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      overflow  <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      for (int i = 0; i < N_ELEM; i++) vec_reg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_in <= 1'b1;
          if (valid_in && ready_in) begin
            for (int i = 0; i < N_ELEM; i++) vec_reg[i] <= data_in[i*W +: W];
            acc      <= '0;
            idx      <= '0;
            ready_in <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            data_out  <= sat_val;
            overflow  <= sat;
            valid_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (ready_out) begin
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
